// File: rtl/result_writeback_pkg.sv
// Shared types and constants for the result writeback path: element and word geometry, layer codes,
// per-layer and per-phase RAM address stride, FSM state codes and the optional ReLU helper.
package result_writeback_pkg;

   localparam int DATA_LEN        = 8;
   localparam int ELEMS_PER_CHUNK = 9;
   localparam int CHUNKS          = 4;
   localparam int CHUNK_W         = ELEMS_PER_CHUNK * DATA_LEN;
   localparam int WORD_W          = CHUNKS * CHUNK_W;
   localparam int LAYER_WORDS     = 32;
   localparam int PHASE_WORDS     = 4;

   localparam logic [3:0] LAYER0 = 4'd0;
   localparam logic [3:0] LAYER1 = 4'd1;
   localparam logic [3:0] LAYER2 = 4'd2;
   localparam logic [3:0] LAYER3 = 4'd3;
   localparam logic [3:0] AFFINE = 4'd4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef logic [CHUNK_W-1:0] chunk_t;
   typedef logic [WORD_W-1:0]  word_t;

   // Zero every signed element whose sign bit is set.
   function automatic word_t reluWord(input word_t w);
      word_t r;
      r = w;
      for (int e = 0; e < WORD_W / DATA_LEN; e++) begin
         if (w[e*DATA_LEN + DATA_LEN - 1]) begin
            r[e*DATA_LEN +: DATA_LEN] = '0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/result_writeback_layer_addr_offset.sv
// Maps (layer code, phase) to the RAM base address of that phase's block and flags unknown layer codes.
// Shared with the weight loader so both sides agree on the feature RAM layout.
module layer_addr_offset
   import result_writeback_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic [3:0]        i_cs,
   input  logic [2:0]        i_phase,
   output logic [ADDR_W-1:0] o_base,
   output logic              o_legal
);

   logic [ADDR_W-1:0] w_csOff;

   always_comb begin
      w_csOff = '0;
      o_legal = 1'b1;
      case (i_cs)
         LAYER0:  w_csOff = ADDR_W'(0 * LAYER_WORDS);
         LAYER1:  w_csOff = ADDR_W'(1 * LAYER_WORDS);
         LAYER2:  w_csOff = ADDR_W'(2 * LAYER_WORDS);
         LAYER3:  w_csOff = ADDR_W'(3 * LAYER_WORDS);
         AFFINE:  w_csOff = ADDR_W'(4 * LAYER_WORDS);
         default: o_legal = 1'b0;
      endcase
   end

   assign o_base = w_csOff + ADDR_W'(PHASE_WORDS) * ADDR_W'(i_phase);

endmodule

// File: rtl/result_writeback.sv
// Serialises one compute-array result word into CHUNKS consecutive feature-RAM writes.
// Optional build macro RESULT_WB_RELU_EN zeroes negative elements before they are written.
module result_writeback
   import result_writeback_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_store,
   input  logic [3:0]         i_cs,
   input  logic [2:0]         i_phase,
   input  logic               i_valid_in,
   input  logic [WORD_W-1:0]  i_d,
   output logic               o_ready,
   output logic               o_ram_we,
   output logic [ADDR_W-1:0]  o_ram_addr,
   output logic [CHUNK_W-1:0] o_ram_d,
   output logic               o_done,
   output logic               o_err
);

   logic [1:0]        r_state;
   logic [1:0]        r_k;
   word_t             r_capture;
   logic [ADDR_W-1:0] r_base;
   logic              r_ramWe;
   logic [ADDR_W-1:0] r_ramAddr;
   chunk_t            r_ramD;
   logic              r_done;
   logic              r_err;

   logic [ADDR_W-1:0] w_base;
   logic              w_legal;
   word_t             w_dProc;
   logic [1:0]        w_nextK;

   layer_addr_offset #(.ADDR_W(ADDR_W)) u_addrOffset (
      .i_cs    (i_cs),
      .i_phase (i_phase),
      .o_base  (w_base),
      .o_legal (w_legal)
   );

`ifdef RESULT_WB_RELU_EN
   assign w_dProc = reluWord(i_d);
`else
   assign w_dProc = i_d;
`endif

   assign w_nextK = r_k + 2'd1;

   // The first chunk is issued straight from the accept edge so writes begin one cycle after accept;
   // dropping store abandons whatever is in flight and re-arms the block.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_k       <= '0;
         r_capture <= '0;
         r_base    <= '0;
         r_ramWe   <= 1'b0;
         r_ramAddr <= '0;
         r_ramD    <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else if (!i_store) begin
         r_state <= ST_IDLE;
         r_ramWe <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_valid_in) begin
                  if (w_legal) begin
                     r_capture <= w_dProc;
                     r_base    <= w_base;
                     r_k       <= '0;
                     r_ramWe   <= 1'b1;
                     r_ramAddr <= w_base;
                     r_ramD    <= w_dProc[0 +: CHUNK_W];
                     r_state   <= ST_WRITE;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (r_k == 2'(CHUNKS - 1)) begin
                  r_ramWe <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_k       <= w_nextK;
                  r_ramAddr <= r_base + ADDR_W'(w_nextK);
                  r_ramD    <= r_capture[w_nextK*CHUNK_W +: CHUNK_W];
               end
            end
            ST_DONE: begin
               r_state <= ST_DONE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_ready    = (r_state == ST_IDLE) && !i_rst;
   assign o_ram_we   = r_ramWe;
   assign o_ram_addr = r_ramAddr;
   assign o_ram_d    = r_ramD;
   assign o_done     = r_done;
   assign o_err      = r_err;

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback: a directed table of layer/phase cases plus randomized
// transactions, all compared against an element-level reference model of the write sequence.
module tb_result_writeback;
   import result_writeback_pkg::*;

   localparam int ADDR_W = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               store;
   logic [3:0]         cs;
   logic [2:0]         phase;
   logic               validIn;
   word_t              d;
   logic               ready;
   logic               ramWe;
   logic [ADDR_W-1:0]  ramAddr;
   chunk_t             ramD;
   logic               done;
   logic               err;

   int checks = 0;
   int errors = 0;
   bit expErr = 1'b0;

   typedef struct {
      logic [3:0] cs;
      logic [2:0] phase;
      int         dropAt;
      int         expBase;
      bit         expLegal;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   result_writeback #(.ADDR_W(ADDR_W)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_store    (store),
      .i_cs       (cs),
      .i_phase    (phase),
      .i_valid_in (validIn),
      .i_d        (d),
      .o_ready    (ready),
      .o_ram_we   (ramWe),
      .o_ram_addr (ramAddr),
      .o_ram_d    (ramD),
      .o_done     (done),
      .o_err      (err)
   );

   function automatic word_t randomWord();
      word_t w;
      for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // Chunk k holds elements 9k..9k+8; negative elements become 0 when ReLU is built in.
   function automatic chunk_t modelChunk(input word_t w, input int k);
      chunk_t     r;
      logic [7:0] v;
      r = '0;
      for (int i = 0; i < ELEMS_PER_CHUNK; i++) begin
         v = w[(k*ELEMS_PER_CHUNK + i)*DATA_LEN +: DATA_LEN];
`ifdef RESULT_WB_RELU_EN
         if ($signed(v) < 0) v = 8'h00;
`endif
         r[i*DATA_LEN +: DATA_LEN] = v;
      end
      return r;
   endfunction

   // Layer n of the ordered list LAYER0..LAYER3, AFFINE owns words n*32..n*32+31; -1 means illegal.
   function automatic int modelBase(input logic [3:0] c, input logic [2:0] p);
      logic [3:0] codes[5];
      codes = '{LAYER0, LAYER1, LAYER2, LAYER3, AFFINE};
      for (int n = 0; n < 5; n++) begin
         if (codes[n] == c) return n * LAYER_WORDS + int'(p) * PHASE_WORDS;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic checkQuiet(input string tag, input bit expReady, input bit expDone);
      checkOutput({tag, ".we"},    96'(ramWe), 96'(0));
      checkOutput({tag, ".ready"}, 96'(ready), 96'(expReady));
      checkOutput({tag, ".done"},  96'(done),  96'(expDone));
      checkOutput({tag, ".err"},   96'(err),   96'(expErr));
   endtask

   // One transaction starting at a negedge in IDLE; dropAt=j lowers store during write cycle T+j.
   task automatic applyStimulus(input logic [3:0] c, input logic [2:0] p, input word_t w,
                                input int dropAt, input int expBase, input bit expLegal);
      string tag;
      bit    dropped;
      tag = $sformatf("cs%0h.ph%0d.drop%0d", c, p, dropAt);
      store   = 1'b1;
      validIn = 1'b1;
      cs      = c;
      phase   = p;
      d       = w;
      checkOutput({tag, ".readyAtAccept"}, 96'(ready), 96'(1));
      @(negedge clk);
      if (!expLegal) begin
         expErr = 1'b1;
         checkQuiet({tag, ".illegal"}, 1'b1, 1'b0);
         store   = 1'b0;
         validIn = 1'b0;
         @(negedge clk);
         checkQuiet({tag, ".illegalAfter"}, 1'b1, 1'b0);
         return;
      end
      for (int j = 1; j <= CHUNKS; j++) begin
         dropped = (dropAt != 0) && (j > dropAt);
         if (dropped) begin
            checkQuiet($sformatf("%s.t%0d", tag, j), 1'b1, 1'b0);
         end else begin
            checkOutput($sformatf("%s.t%0d.we", tag, j),    96'(ramWe),   96'(1));
            checkOutput($sformatf("%s.t%0d.addr", tag, j),  96'(ramAddr), 96'(expBase + j - 1));
            checkOutput($sformatf("%s.t%0d.data", tag, j),  96'(ramD),    96'(modelChunk(w, j - 1)));
            checkOutput($sformatf("%s.t%0d.ready", tag, j), 96'(ready),   96'(0));
            checkOutput($sformatf("%s.t%0d.done", tag, j),  96'(done),    96'(0));
         end
         cs      = 4'($urandom);
         phase   = 3'($urandom);
         d       = randomWord();
         validIn = store && 1'($urandom);
         if (dropAt == j) begin
            store   = 1'b0;
            validIn = 1'b0;
         end
         @(negedge clk);
      end
      if (dropAt != 0) begin
         checkQuiet({tag, ".afterDrop"}, 1'b1, 1'b0);
      end else begin
         checkQuiet({tag, ".done"}, 1'b0, 1'b1);
         validIn = 1'b1;
         @(negedge clk);
         checkQuiet({tag, ".doneHeld"}, 1'b0, 1'b1);
         store   = 1'b0;
         validIn = 1'b0;
         @(negedge clk);
         checkQuiet({tag, ".rearm"}, 1'b1, 1'b0);
      end
      store   = 1'b0;
      validIn = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      word_t      w;
      int         base;
      int         drop;
      logic [3:0] rc;
      logic [2:0] rp;

      rst = 1'b1; store = 1'b0; validIn = 1'b0; cs = '0; phase = '0; d = '0;
      @(negedge clk);
      checkQuiet("reset1", 1'b0, 1'b0);
      checkOutput("reset1.addr", 96'(ramAddr), 96'(0));
      checkOutput("reset1.data", 96'(ramD),    96'(0));
      @(negedge clk);
      checkQuiet("reset2", 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      checkQuiet("afterReset", 1'b1, 1'b0);

      vecs[0] = '{LAYER1, 3'd2, 0,  40, 1'b1};
      vecs[1] = '{AFFINE, 3'd7, 0, 156, 1'b1};
      vecs[2] = '{LAYER0, 3'd0, 0,   0, 1'b1};
      vecs[3] = '{LAYER3, 3'd5, 0, 116, 1'b1};
      vecs[4] = '{LAYER1, 3'd2, 2,  40, 1'b1};
      vecs[5] = '{LAYER2, 3'd3, 4,  76, 1'b1};
      vecs[6] = '{4'hF,   3'd3, 0,   0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].cs, vecs[i].phase, randomWord(), vecs[i].dropAt,
                       vecs[i].expBase, vecs[i].expLegal);
      end

      for (int e = 0; e < WORD_W / DATA_LEN; e++) begin
         w[e*DATA_LEN +: DATA_LEN] = (e % 2 == 0) ? 8'h80 : 8'h05;
      end
      applyStimulus(LAYER2, 3'd1, w, 0, 68, 1'b1);

      rst = 1'b1; store = 1'b1; validIn = 1'b1; cs = LAYER1; d = randomWord();
      @(negedge clk);
      expErr = 1'b0;
      checkQuiet("rstPriority", 1'b0, 1'b0);
      rst = 1'b0; store = 1'b0; validIn = 1'b0;
      @(negedge clk);
      checkQuiet("errCleared", 1'b1, 1'b0);

      for (int t = 0; t < 24; t++) begin
         if ($urandom_range(0, 7) < 6) rc = 4'($urandom_range(0, 4));
         else rc = 4'($urandom_range(5, 15));
         rp   = 3'($urandom);
         drop = $urandom_range(0, 7);
         if (drop > CHUNKS) drop = 0;
         base = modelBase(rc, rp);
         applyStimulus(rc, rp, randomWord(), drop, base, base >= 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
